// File: rtl/axis_len_pkg.sv
// Shared types and helpers for the AXI-Stream packet length enforcer.
package axis_len_pkg;

   typedef enum logic [1:0] {
      PASS    = 2'd0,
      PAD     = 2'd1,
      DISCARD = 2'd2
   } len_state_t;

   // Width of a counter that must hold values 0..max_beats.
   function automatic int beat_ctr_width(input int max_beats);
      return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             sresetn,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count events, holding once every bit is set so the value never wraps.
   always_ff @(posedge clk) begin
      if (!sresetn) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/axis_packet_len_enforcer.sv
// Bounds each AXI-Stream packet to MIN_BEATS..MAX_BEATS beats by padding
// short packets and truncating long ones; PASS is a zero-latency path.
module axis_packet_len_enforcer
   import axis_len_pkg::*;
#(
   parameter int         AXIS_BYTES = 1,
   parameter int         MIN_BEATS  = 4,
   parameter int         MAX_BEATS  = 1024,
   parameter logic [7:0] PAD_BYTE   = 8'h00,
   parameter int         CTR_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    sresetn,
   output logic                    axis_i_tready,
   input  logic                    axis_i_tvalid,
   input  logic                    axis_i_tlast,
   input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
   input  logic                    axis_o_tready,
   output logic                    axis_o_tvalid,
   output logic                    axis_o_tlast,
   output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
   output logic [CTR_WIDTH-1:0]    pad_count,
   output logic [CTR_WIDTH-1:0]    trunc_count
);

   localparam int            BW    = beat_ctr_width(MAX_BEATS);
   localparam logic [BW-1:0] MIN_L = BW'(MIN_BEATS);
   localparam logic [BW-1:0] MAX_L = BW'(MAX_BEATS);

   len_state_t    state, state_nxt, state_eff;
   logic [BW-1:0] beat_ctr, beat_nxt, beat_eff, beat_inc;
   logic          at_max, reach_min, pass_last, pad_last;
   logic          pad_inc, trunc_inc;

   // While reset is held the outputs behave as PASS with an empty packet,
   // independent of whatever the registers held before the reset edge.
   assign state_eff = sresetn ? state : PASS;
   assign beat_eff  = sresetn ? beat_ctr : '0;
   assign beat_inc  = beat_eff + BW'(1);
   assign at_max    = (beat_inc == MAX_L);
   assign reach_min = (beat_inc >= MIN_L);
   assign pass_last = at_max || (axis_i_tlast && reach_min);
   assign pad_last  = (beat_inc == MIN_L);

   // Next-state, beat counter update and stream outputs per state.
   always_comb begin
      state_nxt     = state_eff;
      beat_nxt      = beat_eff;
      pad_inc       = 1'b0;
      trunc_inc     = 1'b0;
      axis_i_tready = 1'b0;
      axis_o_tvalid = 1'b0;
      axis_o_tlast  = 1'b0;
      axis_o_tdata  = axis_i_tdata;
      case (state_eff)
         PASS: begin
            axis_o_tvalid = axis_i_tvalid;
            axis_i_tready = axis_o_tready;
            axis_o_tlast  = pass_last;
            if (axis_i_tvalid && axis_o_tready) begin
               // Truncation is checked first so MIN_BEATS == MAX_BEATS works.
               if (at_max && !axis_i_tlast) begin
                  state_nxt = DISCARD;
                  beat_nxt  = '0;
                  trunc_inc = 1'b1;
               end else if (axis_i_tlast && !reach_min) begin
                  state_nxt = PAD;
                  beat_nxt  = beat_inc;
                  pad_inc   = 1'b1;
               end else if (pass_last) begin
                  beat_nxt = '0;
               end else begin
                  beat_nxt = beat_inc;
               end
            end
         end
         PAD: begin
            axis_o_tvalid = 1'b1;
            axis_o_tdata  = {AXIS_BYTES{PAD_BYTE}};
            axis_o_tlast  = pad_last;
            if (axis_o_tready) begin
               if (pad_last) begin
                  state_nxt = PASS;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_inc;
               end
            end
         end
         DISCARD: begin
            axis_i_tready = 1'b1;
            if (axis_i_tvalid && axis_i_tlast) begin
               state_nxt = PASS;
            end
         end
         default: begin
            state_nxt = PASS;
            beat_nxt  = '0;
         end
      endcase
   end

   // State and beat counter registers.
   always_ff @(posedge clk) begin
      if (!sresetn) begin
         state    <= PASS;
         beat_ctr <= '0;
      end else begin
         state    <= state_nxt;
         beat_ctr <= beat_nxt;
      end
   end

   sat_counter #(.WIDTH(CTR_WIDTH)) u_pad_ctr (
      .clk     (clk),
      .sresetn (sresetn),
      .inc     (pad_inc),
      .count   (pad_count)
   );

   sat_counter #(.WIDTH(CTR_WIDTH)) u_trunc_ctr (
      .clk     (clk),
      .sresetn (sresetn),
      .inc     (trunc_inc),
      .count   (trunc_count)
   );

endmodule

// File: tb/tb_axis_packet_len_enforcer.sv
// Randomised and directed bench for axis_packet_len_enforcer with a
// packet-level reference model (pad / truncate whole packets into a queue).
module tb_axis_packet_len_enforcer;

   localparam int MINB = 4;
   localparam int MAXB = 8;

   logic       clk = 1'b0;
   logic       sresetn = 1'b0;
   logic       axis_i_tready, axis_i_tvalid, axis_i_tlast;
   logic [7:0] axis_i_tdata;
   logic       axis_o_tready, axis_o_tvalid, axis_o_tlast;
   logic [7:0] axis_o_tdata;
   logic [15:0] pad_count, trunc_count;
   logic       i2_tready, o2_tvalid, o2_tlast;
   logic [7:0] o2_tdata;
   logic [1:0] pad_count2, trunc_count2;

   always #5 clk = ~clk;

   axis_packet_len_enforcer #(
      .AXIS_BYTES(1), .MIN_BEATS(MINB), .MAX_BEATS(MAXB), .PAD_BYTE(8'h00), .CTR_WIDTH(16)
   ) u_dut (
      .clk(clk), .sresetn(sresetn),
      .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
      .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
      .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
      .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata),
      .pad_count(pad_count), .trunc_count(trunc_count)
   );

   // Narrow-counter copy fed the same stream, for saturation.
   axis_packet_len_enforcer #(
      .AXIS_BYTES(1), .MIN_BEATS(MINB), .MAX_BEATS(MAXB), .PAD_BYTE(8'h00), .CTR_WIDTH(2)
   ) u_dut2 (
      .clk(clk), .sresetn(sresetn),
      .axis_i_tready(i2_tready), .axis_i_tvalid(axis_i_tvalid),
      .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
      .axis_o_tready(axis_o_tready), .axis_o_tvalid(o2_tvalid),
      .axis_o_tlast(o2_tlast), .axis_o_tdata(o2_tdata),
      .pad_count(pad_count2), .trunc_count(trunc_count2)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   int         total = 0;
   int         bad = 0;
   beat_t      exp_q[$];
   logic [7:0] pkt_q[$];
   int         m_pad = 0;
   int         m_trunc = 0;
   int         ready_pct = 100;
   int         gap_pct = 0;
   bit         sink_en = 0;
   int         rdy_low_hs = 0;
   int         out_hs = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_d;
   logic       prev_l;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: whole-packet transform from the length rules.
   task automatic model_pkt();
      int n = pkt_q.size();
      beat_t b;
      if (n > MAXB) begin
         for (int i = 0; i < MAXB; i++) begin
            b.d = pkt_q[i]; b.l = (i == MAXB - 1); exp_q.push_back(b);
         end
         m_trunc++;
      end else if (n < MINB) begin
         for (int i = 0; i < MINB; i++) begin
            b.d = (i < n) ? pkt_q[i] : 8'h00; b.l = (i == MINB - 1); exp_q.push_back(b);
         end
         m_pad++;
      end else begin
         for (int i = 0; i < n; i++) begin
            b.d = pkt_q[i]; b.l = (i == n - 1); exp_q.push_back(b);
         end
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l);
      bit hs = 0;
      while ($urandom_range(99) < gap_pct) begin
         axis_i_tvalid = 1'b0;
         @(posedge clk); #1;
      end
      axis_i_tvalid = 1'b1; axis_i_tdata = d; axis_i_tlast = l;
      for (int k = 0; k < 300 && !hs; k++) begin
         @(negedge clk); hs = axis_i_tready;
         @(posedge clk); #1;
      end
      if (!hs) check("send_timeout", 64'd0, 64'd1);
      axis_i_tvalid = 1'b0; axis_i_tlast = 1'b0;
   endtask

   task automatic send_pkt();
      model_pkt();
      for (int i = 0; i < pkt_q.size(); i++) send_beat(pkt_q[i], i == pkt_q.size() - 1);
   endtask

   task automatic make_pkt(input logic [7:0] first, input int n);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(first + 8'(i));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_ctrs();
      check("pad_count", 64'(pad_count), 64'(m_pad));
      check("trunc_count", 64'(trunc_count), 64'(m_trunc));
      check("pad_count2", 64'(pad_count2), 64'((m_pad > 3) ? 3 : m_pad));
      check("trunc_count2", 64'(trunc_count2), 64'((m_trunc > 3) ? 3 : m_trunc));
   endtask

   // Sink: drive output ready with the configured probability.
   always @(posedge clk) begin
      if (sink_en) begin
         #1 axis_o_tready = ($urandom_range(99) < ready_pct);
      end
   end

   // Compare every output handshake against the model; check stall stability.
   always @(negedge clk) begin
      beat_t b;
      if (!sresetn) begin
         prev_stall = 0;
      end else begin
         if (prev_stall)
            check("stall_hold", {axis_o_tvalid, axis_o_tdata, axis_o_tlast},
                  {1'b1, prev_d, prev_l});
         if (axis_o_tvalid && axis_o_tready) begin
            out_hs++;
            if (!axis_i_tready) rdy_low_hs++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {axis_o_tdata, axis_o_tlast}, 64'd0);
            end else begin
               b = exp_q.pop_front();
               check("out_beat", {axis_o_tdata, axis_o_tlast}, {b.d, b.l});
               check("dut2_beat", {o2_tvalid, o2_tdata, o2_tlast}, {1'b1, b.d, b.l});
            end
         end
         prev_stall = axis_o_tvalid && !axis_o_tready;
         prev_d = axis_o_tdata;
         prev_l = axis_o_tlast;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b;
      axis_i_tvalid = 1'b0; axis_i_tlast = 1'b0; axis_i_tdata = 8'h00;
      axis_o_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pad", 64'(pad_count), 64'd0);
      check("rst_trunc", 64'(trunc_count), 64'd0);
      check("rst_tready_follow1", 64'(axis_i_tready), 64'd1);
      check("rst_tvalid", 64'(axis_o_tvalid), 64'd0);
      axis_o_tready = 1'b0;
      #1;
      check("rst_tready_follow0", 64'(axis_i_tready), 64'd0);
      @(posedge clk); #1;
      axis_o_tready = 1'b1;
      sresetn = 1'b1;
      @(posedge clk); #1;
      sink_en = 1;

      // 6-beat pass-through
      make_pkt(8'h01, 6); send_pkt(); drain(); check_ctrs();
      check("s1_pad_lit", 64'(pad_count), 64'd0);

      // exactly MIN and exactly MAX
      make_pkt(8'h50, 4); send_pkt();
      make_pkt(8'h60, 8); send_pkt(); drain();
      check("exact_pad_lit", 64'(pad_count), 64'd0);
      check("exact_trunc_lit", 64'(trunc_count), 64'd0);

      // 2-beat short packet
      make_pkt(8'hA1, 2); model_pkt();
      b = exp_q[3];
      check("pin_short_len", 64'(exp_q.size()), 64'd4);
      check("pin_short_b1", {exp_q[1].d, exp_q[1].l}, {8'hA2, 1'b0});
      check("pin_short_b3", {b.d, b.l}, {8'h00, 1'b1});
      rdy_low_hs = 0;
      send_beat(8'hA1, 1'b0); send_beat(8'hA2, 1'b1); drain();
      check("short_rdy_low", 64'(rdy_low_hs), 64'd2);
      check("short_pad_lit", 64'(pad_count), 64'd1);

      // 11-beat truncated packet then a 5-beat packet
      out_hs = 0;
      make_pkt(8'h10, 11); model_pkt();
      make_pkt(8'h20, 5); model_pkt();
      check("pin_trunc_len", 64'(exp_q.size()), 64'd13);
      check("pin_trunc_b7", {exp_q[7].d, exp_q[7].l}, {8'h17, 1'b1});
      make_pkt(8'h10, 11);
      for (int i = 0; i < 11; i++) send_beat(pkt_q[i], i == 10);
      make_pkt(8'h20, 5);
      for (int i = 0; i < 5; i++) send_beat(pkt_q[i], i == 4);
      drain();
      check("trunc_out_hs", 64'(out_hs), 64'd13);
      check("trunc_lit", 64'(trunc_count), 64'd1);
      check_ctrs();

      // reset while discarding, then a 4-beat packet
      for (int i = 0; i < MAXB; i++) begin
         b.d = 8'h30 + 8'(i); b.l = (i == MAXB - 1); exp_q.push_back(b);
      end
      m_trunc++;
      for (int i = 0; i < 10; i++) send_beat(8'h30 + 8'(i), 1'b0);
      drain(); check_ctrs();
      sresetn = 1'b0; @(posedge clk); #1; sresetn = 1'b1;
      m_pad = 0; m_trunc = 0;
      make_pkt(8'h40, 4); send_pkt(); drain();
      check("post_rst_pad", 64'(pad_count), 64'd0);
      check("post_rst_trunc", 64'(trunc_count), 64'd0);

      // five short packets: narrow counter saturates
      for (int p = 0; p < 5; p++) begin
         make_pkt(8'h70 + 8'(p), 1); send_pkt();
      end
      drain();
      check("sat_pad2_lit", 64'(pad_count2), 64'd3);
      check("sat_pad_lit", 64'(pad_count), 64'd5);
      check_ctrs();

      // randomised traffic with backpressure and input gaps
      ready_pct = 50; gap_pct = 30;
      for (int p = 0; p < 40; p++) begin
         int n = $urandom_range(12, 1);
         pkt_q.delete();
         for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
         send_pkt();
      end
      drain();
      check_ctrs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_packet_len_enforcer.md
Name: axis_packet_len_enforcer

Overview:
Stream-conditioning stage placed directly upstream of the packet FIFO. It bounds every packet to between MIN_BEATS and MAX_BEATS beats:
- Short packets are padded with PAD_BYTE.
- Long packets are truncated at MAX_BEATS, and the remaining input beats are discarded.
- With MAX_BEATS <= FIFO depth, the downstream FIFO never enters its full-without-tlast pass-through case.
- Saturating counters report how many packets were padded or truncated.

Parameters:
AXIS_BYTES, 1, data width in bytes (tdata = AXIS_BYTES*8 bits)
MIN_BEATS, 4, minimum output packet length in beats; must be >= 1
MAX_BEATS, 1024, maximum output packet length in beats; must be >= MIN_BEATS
PAD_BYTE, 8'h00, value replicated into every byte lane of pad beats
CTR_WIDTH, 16, width of the statistics counters

Ports:
clk  input  1  clock
sresetn  input  1  synchronous active-low reset
axis_i_tready  output  1  input stream ready
axis_i_tvalid  input  1  input stream valid
axis_i_tlast  input  1  input stream end of packet
axis_i_tdata  input  AXIS_BYTES*8  input stream data
axis_o_tready  input  1  output stream ready
axis_o_tvalid  output  1  output stream valid
axis_o_tlast  output  1  output stream end of packet
axis_o_tdata  output  AXIS_BYTES*8  output stream data
pad_count  output  CTR_WIDTH  number of packets padded, saturating
trunc_count  output  CTR_WIDTH  number of packets truncated, saturating

Behaviour:
- Clock and reset: clk, with reset sresetn (synchronous, active-low).
- On reset: state=PASS, beat_ctr=0, pad_count=0, trunc_count=0.
  - Outputs during reset follow PASS combinational rules with beat_ctr=0.
- beat_ctr counts output beats already sent in the current packet.
  - Width: $clog2(MAX_BEATS+1).
  - It never exceeds MAX_BEATS-1 between packets.
- State PASS: zero-latency combinational path.
  - axis_o_tvalid = axis_i_tvalid; axis_o_tdata = axis_i_tdata; axis_i_tready = axis_o_tready.
  - axis_o_tlast = (beat_ctr+1 == MAX_BEATS) || (axis_i_tlast && beat_ctr+1 >= MIN_BEATS).
  - On an output handshake, the first matching rule applies:
    - Truncation: if beat_ctr+1 == MAX_BEATS and !axis_i_tlast, go to DISCARD, set beat_ctr=0, increment trunc_count.
    - Short packet: else if axis_i_tlast and beat_ctr+1 < MIN_BEATS, go to PAD, set beat_ctr=beat_ctr+1, increment pad_count. The output tlast is suppressed on this beat.
    - End of packet: else if axis_o_tlast, set beat_ctr=0 and stay in PASS.
    - Otherwise: beat_ctr++.
  - The truncation rule takes priority, so MIN_BEATS == MAX_BEATS is legal.
- State PAD:
  - axis_i_tready=0, axis_o_tvalid=1, axis_o_tdata={AXIS_BYTES{PAD_BYTE}}.
  - axis_o_tlast = (beat_ctr+1 == MIN_BEATS).
  - On handshake: if tlast, return to PASS with beat_ctr=0; otherwise beat_ctr++.
  - axis_o_tvalid stays high until the pad beat is accepted; tdata is stable under backpressure.
- State DISCARD:
  - axis_i_tready=1, axis_o_tvalid=0, axis_o_tlast=0.
  - On an input handshake with tlast, return to PASS.
  - Input tvalid gaps are tolerated indefinitely.
- A packet of exactly MAX_BEATS with tlast on the last beat is not counted as truncated.
- A packet of exactly MIN_BEATS is not counted as padded.
- Statistics counters hold at all-ones once saturated and never wrap.
- axis_i_tready must not depend on axis_i_tvalid. axis_o_tvalid must not depend on axis_o_tready.
- Reset mid-packet: the state machine restarts in PASS immediately. Downstream sees a partial packet; callers reset the whole pipeline together.

Decomposition:
- Package axis_len_pkg holds:
  - typedef enum logic [1:0] {PASS, PAD, DISCARD} len_state_t
  - a function computing the beat_ctr width from MAX_BEATS.
- One sub-module, sat_counter (parameter WIDTH; inputs clk, sresetn, inc; output count), is instantiated twice for pad_count and trunc_count.

Test Plan:
All scenarios use AXIS_BYTES=1, MIN_BEATS=4, MAX_BEATS=8, PAD_BYTE=8'h00.
- 6-beat packet 01..06, continuous ready -> output 01..06 unchanged, tlast on beat 6, pad_count=0, trunc_count=0.
- 2-beat packet A1,A2 -> output A1,A2,00,00 with tlast only on the 4th beat; axis_i_tready low for 2 handshake cycles; pad_count=1.
- 11-beat packet 10..1A, then 5-beat packet 20..24 -> output 10..17 with tlast on 17; 18..1A accepted with no output; trunc_count=1; second packet output intact.
- Exactly 4-beat and exactly 8-beat packets -> both pass unmodified; both counters remain 0.
- Random output backpressure and input tvalid gaps across all three states -> no beat lost or duplicated; data and tlast stable while tvalid && !tready; output matches the reference model.
- sresetn asserted for 1 cycle during DISCARD, then a 4-beat packet -> packet passes intact; counters read 0; CTR_WIDTH=2 with 5 short packets -> pad_count holds at 3.
